// File: rtl/npc_pkg.sv
// Shared next-PC definitions: npc_sel mode encodings and default
// reset / exception entry addresses for the fetch PC generator.
package npc_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'b000,
    NPC_BEQ  = 3'b001,
    NPC_J    = 3'b010,
    NPC_JR   = 3'b011,
    NPC_EXC  = 3'b100,
    NPC_ERET = 3'b101,
    NPC_BNE  = 3'b110,
    NPC_RSV  = 3'b111
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack used to predict JR $31 targets. A push while
// full wraps the pointer and overwrites the oldest entry; the count
// saturates at DEPTH. Popping an empty stack is ignored here; the
// parent is expected to gate pop with empty.
module pc_ras
  import npc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;    // next free slot; ptr-1 is the top
  logic [CNT_W-1:0]  count;

  assign top   = mem[ptr - PTR_W'(1)];
  assign empty = (count == '0);

  // Entry storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= push_data;
    end
  end

  // Pointer and occupancy; pointer wraps naturally since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) begin
        count <= count + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: next-PC mux for sequential, branch, jump, register
// jump, exception and ERET flow, interrupt override with a pending
// latch, and an advisory return-address stack that flags JR $31
// mispredictions and empty-stack pops.
module pc_gen
  import npc_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(EXC_VEC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        npc_sel,
  input  logic              zero,
  input  logic              link,
  input  logic              rs_is_ra,
  input  logic [25:0]       imme,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-3:0] epc,
  input  logic              int_req,
  output logic              int_ack,
  output logic [ADDR_W-3:0] exc_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_4,
  output logic [ADDR_W-1:0] npc,
  output logic              ras_miss,
  output logic              ras_underflow,
  output logic              ras_empty
);

  // Branch displacement: word offset sign-extended to a byte offset.
  function automatic logic signed [ADDR_W-1:0] br_offset(input logic [15:0] off);
    logic signed [17:0] byte_off;
    byte_off = {off, 2'b00};
    return ADDR_W'(byte_off);
  endfunction

  npc_sel_e          sel;
  logic              pending;
  logic              int_take;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] npc_base;
  logic              ras_push;
  logic              ras_pop_req;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;

  assign sel       = npc_sel_e'(npc_sel);
  assign pc_4      = pc + ADDR_W'(4);
  assign br_target = pc_4 + $unsigned(br_offset(imme[15:0]));
  // A same-cycle request counts as pending so it beats ERET/JR etc.
  assign int_take  = (pending | int_req) & ~stall;

  // Next-PC selection before interrupt override; 111 falls back to SEQ.
  always_comb begin
    npc_base = pc_4;
    unique case (sel)
      NPC_SEQ:  npc_base = pc_4;
      NPC_BEQ:  npc_base = zero ? br_target : pc_4;
      NPC_BNE:  npc_base = zero ? pc_4 : br_target;
      NPC_J:    npc_base = {pc_4[ADDR_W-1:28], imme, 2'b00};
      NPC_JR:   npc_base = rs;
      NPC_EXC:  npc_base = EXC_VEC;
      NPC_ERET: npc_base = {epc, 2'b00};
      NPC_RSV:  npc_base = pc_4;
      default:  npc_base = pc_4;
    endcase
  end

  assign npc = int_take ? EXC_VEC : npc_base;

  // RAS only moves on committed, non-interrupted cycles.
  assign ras_push    = ~stall & ~int_take & (sel == NPC_J) & link;
  assign ras_pop_req = ~stall & ~int_take & (sel == NPC_JR) & rs_is_ra;
  assign ras_pop     = ras_pop_req & ~ras_empty;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_4),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  // Program counter register; stall freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (!stall) begin
      pc <= npc;
    end
  end

  // Interrupt pending latch, acknowledge pulse and return address capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      int_ack <= 1'b0;
      exc_pc  <= '0;
    end else begin
      int_ack <= int_take;
      if (int_take) begin
        pending <= 1'b0;
        exc_pc  <= pc[ADDR_W-1:2];
      end else if (int_req) begin
        pending <= 1'b1;
      end
    end
  end

  // One-cycle prediction status pulses for JR $31.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_miss      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_miss      <= ras_pop & (ras_top != rs);
      ras_underflow <= ras_pop_req & ras_empty;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized
// run against a queue-based behavioural model of the PC generator.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, zero, link, rs_is_ra, int_req;
  logic [2:0]  npc_sel;
  logic [25:0] imme;
  logic [31:0] rs;
  logic [29:0] epc;
  logic        int_ack, ras_miss, ras_underflow, ras_empty;
  logic [29:0] exc_pc;
  logic [31:0] pc, pc_4, npc;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_pend, m_ack, m_miss, m_uf;
  logic [29:0] m_exc;
  logic [31:0] m_ras[$];

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .npc_sel(npc_sel), .zero(zero),
    .link(link), .rs_is_ra(rs_is_ra), .imme(imme), .rs(rs), .epc(epc),
    .int_req(int_req), .int_ack(int_ack), .exc_pc(exc_pc), .pc(pc),
    .pc_4(pc_4), .npc(npc), .ras_miss(ras_miss),
    .ras_underflow(ras_underflow), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; npc_sel = 3'd0; zero = 0; link = 0; rs_is_ra = 0;
    imme = '0; rs = '0; epc = '0; int_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  function automatic logic [31:0] mdl_npc();
    logic [31:0] p4;
    int off;
    p4  = m_pc + 32'd4;
    off = int'($signed(imme[15:0])) * 4;
    if ((m_pend || int_req) && !stall) return 32'h0000_4180;
    case (npc_sel)
      3'd1: return zero ? p4 + 32'(off) : p4;
      3'd6: return zero ? p4 : p4 + 32'(off);
      3'd2: return {p4[31:28], imme, 2'b00};
      3'd3: return rs;
      3'd4: return 32'h0000_4180;
      3'd5: return {epc, 2'b00};
      default: return p4;
    endcase
  endfunction

  task automatic mdl_cycle();
    logic        take;
    logic [31:0] n, t;
    if (rst) begin
      m_pc = 32'h3000; m_pend = 0; m_ack = 0; m_miss = 0; m_uf = 0; m_exc = '0;
      m_ras.delete();
      return;
    end
    take = (m_pend || int_req) && !stall;
    n = mdl_npc();
    m_ack = 0; m_miss = 0; m_uf = 0;
    if (stall) begin
      m_pend = m_pend || int_req;
    end else begin
      if (take) begin
        m_exc = m_pc[31:2]; m_ack = 1; m_pend = 0;
      end else begin
        if (npc_sel == 3'd2 && link) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
        if (npc_sel == 3'd3 && rs_is_ra) begin
          if (m_ras.size() == 0) m_uf = 1;
          else begin
            t = m_ras.pop_back();
            m_miss = (t != rs);
          end
        end
      end
      m_pc = n;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    stall = 1; int_req = 1; rst = 1;
    step();
    idle_inputs();
    n_chk++; if (pc !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, 32'h3000); end
    n_chk++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ras_empty got %b want 1", ras_empty); end
    n_chk++; if ({int_ack, ras_miss, ras_underflow} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b want 000", {int_ack, ras_miss, ras_underflow}); end
    n_chk++; if (exc_pc !== 30'd0) begin n_fail++; $display("FAIL reset_exc_pc got %h want 0", exc_pc); end
    step();
    n_chk++; if (int_ack !== 1'b0) begin n_fail++; $display("FAIL reset_no_pending got int_ack %b want 0", int_ack); end
  endtask

  task automatic test_seq();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step();
      n_chk++; if (pc !== 32'h3000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc%0d got %h want %h", i, pc, 32'h3000 + 32'(4 * i)); end
    end
    n_chk++; if (pc_4 !== 32'h3010) begin n_fail++; $display("FAIL seq_pc_4 got %h want %h", pc_4, 32'h3010); end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (4) step();
    n_chk++; if (pc !== 32'h3010) begin n_fail++; $display("FAIL br_start got %h want %h", pc, 32'h3010); end
    npc_sel = 3'd1; imme = 26'h000FFFF; zero = 1; #1;
    n_chk++; if (npc !== 32'h3010) begin n_fail++; $display("FAIL beq_taken got %h want %h", npc, 32'h3010); end
    npc_sel = 3'd6; #1;
    n_chk++; if (npc !== 32'h3014) begin n_fail++; $display("FAIL bne_not_taken got %h want %h", npc, 32'h3014); end
    zero = 0; imme = 26'h0000010; #1;
    n_chk++; if (npc !== 32'h3054) begin n_fail++; $display("FAIL bne_fwd got %h want %h", npc, 32'h3054); end
    npc_sel = 3'd1; #1;
    n_chk++; if (npc !== 32'h3014) begin n_fail++; $display("FAIL beq_not_taken got %h want %h", npc, 32'h3014); end
    npc_sel = 3'd5; epc = 30'h0000_0C11; #1;
    n_chk++; if (npc !== 32'h3044) begin n_fail++; $display("FAIL eret got %h want %h", npc, 32'h3044); end
    idle_inputs();
  endtask

  task automatic test_jal_jr();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      npc_sel = 3'd2; link = 1; imme = 26'h0000C40;
      step();
      n_chk++; if (pc !== 32'h3100) begin n_fail++; $display("FAIL jal_pc got %h want %h", pc, 32'h3100); end
      n_chk++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL jal_ras_empty got %b want 0", ras_empty); end
      idle_inputs();
      npc_sel = 3'd3; rs_is_ra = 1; rs = (k == 0) ? 32'h3004 : 32'h3008;
      #1;
      n_chk++; if (npc !== rs) begin n_fail++; $display("FAIL jr_npc got %h want %h", npc, rs); end
      step();
      n_chk++; if (ras_miss !== 1'(k)) begin n_fail++; $display("FAIL jr_miss%0d got %b want %0d", k, ras_miss, k); end
      n_chk++; if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin n_fail++; $display("FAIL jr_pop%0d got empty %b uf %b want 1 0", k, ras_empty, ras_underflow); end
      idle_inputs();
      step();
      n_chk++; if (ras_miss !== 1'b0) begin n_fail++; $display("FAIL jr_miss_pulse got %b want 0", ras_miss); end
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] tgt;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tgt = 32'h3100 + 32'(i * 32'h100);
      npc_sel = 3'd2; link = 1; imme = tgt[27:2];
      step();
      n_chk++; if (pc !== tgt) begin n_fail++; $display("FAIL call%0d_pc got %h want %h", i, pc, tgt); end
    end
    idle_inputs();
    for (int i = 4; i >= 0; i--) begin
      npc_sel = 3'd3; rs_is_ra = 1; rs = 32'h3004 + 32'(i * 32'h100);
      step();
      if (i > 0) begin
        n_chk++; if (ras_miss !== 1'b0 || ras_underflow !== 1'b0) begin n_fail++; $display("FAIL ret%0d got miss %b uf %b want 0 0", i, ras_miss, ras_underflow); end
      end else begin
        n_chk++; if (ras_underflow !== 1'b1 || ras_miss !== 1'b0) begin n_fail++; $display("FAIL ret_underflow got uf %b miss %b want 1 0", ras_underflow, ras_miss); end
      end
      if (i == 1) begin
        n_chk++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ras_drained got %b want 1", ras_empty); end
      end
    end
    idle_inputs();
    step();
    n_chk++; if (ras_underflow !== 1'b0) begin n_fail++; $display("FAIL uf_pulse got %b want 0", ras_underflow); end
  endtask

  task automatic test_int_stall();
    do_reset();
    repeat (2) step();
    stall = 1; int_req = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      int_req = 0;
      n_chk++; if (pc !== 32'h3008 || int_ack !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d got pc %h ack %b want 3008 0", i, pc, int_ack); end
    end
    stall = 0; npc_sel = 3'd5; epc = 30'h123; #1;
    n_chk++; if (npc !== 32'h4180) begin n_fail++; $display("FAIL int_npc got %h want %h", npc, 32'h4180); end
    step();
    npc_sel = 3'd0;
    n_chk++; if (pc !== 32'h4180 || int_ack !== 1'b1) begin n_fail++; $display("FAIL int_taken got pc %h ack %b want 4180 1", pc, int_ack); end
    n_chk++; if (exc_pc !== 30'h0C02) begin n_fail++; $display("FAIL int_exc_pc got %h want %h", exc_pc, 30'h0C02); end
    step();
    n_chk++; if (int_ack !== 1'b0 || pc !== 32'h4184) begin n_fail++; $display("FAIL int_ack_pulse got ack %b pc %h want 0 4184", int_ack, pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    npc_sel = 3'd2; link = 1; imme = 26'h0000C40;
    step(); step();
    idle_inputs();
    stall = 1; int_req = 1;
    step();
    rst = 1; int_req = 1;
    step();
    idle_inputs();
    n_chk++; if (pc !== 32'h3000 || ras_empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid got pc %h empty %b want 3000 1", pc, ras_empty); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (int_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack%0d got %b want 0", i, int_ack); end
    end
    n_chk++; if (pc !== 32'h300C) begin n_fail++; $display("FAIL rst_mid_seq got %h want %h", pc, 32'h300C); end
  endtask

  task automatic test_random();
    logic [31:0] exp_npc;
    idle_inputs();
    rst = 1;
    mdl_cycle();
    step();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(63) == 0);
      stall    = ($urandom_range(3) == 0);
      int_req  = ($urandom_range(15) == 0);
      npc_sel  = 3'($urandom_range(7));
      if ($urandom_range(2) == 0) npc_sel = 3'd2;
      if ($urandom_range(2) == 0) npc_sel = 3'd3;
      zero     = 1'($urandom_range(1));
      link     = 1'($urandom_range(1));
      rs_is_ra = ($urandom_range(3) != 0);
      imme     = 26'($urandom);
      rs       = $urandom;
      if (m_ras.size() > 0 && $urandom_range(1) == 1) rs = m_ras[$];
      epc      = 30'($urandom);
      #1;
      if (!rst) begin
        exp_npc = mdl_npc();
        n_chk++; if (npc !== exp_npc) begin n_fail++; $display("FAIL rnd_npc c%0d got %h want %h", c, npc, exp_npc); end
      end
      mdl_cycle();
      step();
      n_chk++;
      if (pc !== m_pc || pc_4 !== m_pc + 32'd4 || int_ack !== m_ack || ras_miss !== m_miss ||
          ras_underflow !== m_uf || ras_empty !== (m_ras.size() == 0) || exc_pc !== m_exc) begin
        n_fail++;
        $display("FAIL rnd_state c%0d got pc %h ack %b miss %b uf %b empty %b exc %h want pc %h ack %b miss %b uf %b empty %b exc %h",
                 c, pc, int_ack, ras_miss, ras_underflow, ras_empty, exc_pc,
                 m_pc, m_ack, m_miss, m_uf, (m_ras.size() == 0), m_exc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_seq();
    test_branch();
    test_jal_jr();
    test_ras_overflow();
    test_int_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC width (min 30).
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning PC after reset.
REQ-004 SHALL have parameter EXC_VEC, default 32'h0000_4180, meaning interrupt/exception entry.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: stall in 1 freeze; npc_sel in 3 next-PC mode; zero in 1 ALU equal flag; link in 1 jump writes $ra; rs_is_ra in 1 JR source is $31.
REQ-007 SHALL have ports: imme in 26 jump index/branch offset; rs in ADDR_W register target; epc in ADDR_W-2 return word address.
REQ-008 SHALL have ports: int_req in 1 interrupt level; int_ack out 1 taken pulse; exc_pc out ADDR_W-2 interrupted word address.
REQ-009 SHALL have ports: pc out ADDR_W current PC; pc_4 out ADDR_W pc+4; npc out ADDR_W next PC.
REQ-010 SHALL have ports: ras_miss out 1 prediction mismatch pulse; ras_underflow out 1 empty-pop pulse; ras_empty out 1.

Function
REQ-011 SHALL decode npc_sel: 000 SEQ, 001 BEQ, 010 J, 011 JR, 100 EXC, 101 ERET, 110 BNE, 111 treated as SEQ.
REQ-012 SHALL compute npc combinationally: SEQ pc_4; BEQ taken if zero, BNE taken if !zero, target pc_4 + sign-extended imme[15:0]<<2, not-taken pc_4; J {pc_4[ADDR_W-1:28], imme, 2'b00}; JR rs; EXC EXC_VEC; ERET {epc, 2'b00}.
REQ-013 SHALL wrap all adds modulo 2^ADDR_W.
REQ-014 SHALL, with pending interrupt and stall=0, override npc to EXC_VEC regardless of npc_sel.
REQ-015 SHALL update pc <= npc on each rising edge with stall=0; stall=1 holds pc, RAS, and pending flag.
REQ-016 SHALL set pending on int_req=1, hold it until taken, and clear it when taken (stall=0).
REQ-017 SHALL, on taking an interrupt, pulse int_ack for one cycle and register exc_pc <= pc[ADDR_W-1:2].
REQ-018 SHALL, in same-cycle int_req and ERET, take the interrupt; ERET is discarded.
REQ-019 SHALL, on J with link=1 (stall=0, no interrupt taken), push pc_4 onto RAS.
REQ-020 SHALL make RAS full-push circular: overwrite the oldest entry; depth stays RAS_DEPTH; no error flag.
REQ-021 SHALL, on JR with rs_is_ra=1 and RAS non-empty, pop and register ras_miss <= (top != rs), a one-cycle pulse next cycle.
REQ-022 SHALL, on pop with RAS empty, leave RAS unchanged and pulse ras_underflow next cycle; ras_miss stays 0.
REQ-023 SHALL keep npc for JR always equal to rs; RAS is advisory only.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, set pc=RESET_PC, RAS empty (ras_empty=1), pending=0, int_ack=0, ras_miss=0, ras_underflow=0, exc_pc=0.
REQ-025 SHALL give rst priority over stall and int_req; reset mid-sequence discards pending interrupt and RAS contents.

Structure
REQ-026 SHALL place npc_sel encodings and default RESET_PC/EXC_VEC constants in shared package npc_pkg.
REQ-027 SHALL implement RAS as sub-module pc_ras: push/pop/top/empty, circular pointer plus count.

Verification
REQ-028 SHALL test: reset, then 3 SEQ cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C.
REQ-029 SHALL test: pc=0x3010, BEQ imme=16'hFFFF zero=1 -> npc 0x3010; BNE same zero=1 -> npc 0x3014.
REQ-030 SHALL test: J link=1 at 0x3000 imme=0x000_0C40 -> pc 0x3100; JR rs_is_ra rs=0x3004 -> ras_miss=0; repeat with rs=0x3008 -> ras_miss=1.
REQ-031 SHALL test: 5 linked calls with RAS_DEPTH=4, then 5 pops -> first 4 return newest-first; 5th pulses ras_underflow.
REQ-032 SHALL test: int_req pulse while stall=1 for 3 cycles -> pc held, then EXC_VEC 0x4180, int_ack single pulse, exc_pc=held pc>>2.
REQ-033 SHALL test: rst asserted with pending interrupt and 2 RAS entries -> pc=0x3000, ras_empty=1, no int_ack afterwards.
